// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with occupancy flags, replace-top,
// indexed peek, synchronous clear and a sticky fault flag.
module param_stack #(
  parameter int width     = 16,
  parameter int depth     = 256,
  parameter int add_width = 8,
  parameter int af_margin = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 peek,
  input  logic [add_width-1:0] peek_off,
  input  logic [width-1:0]     wr,
  output logic [width-1:0]     rd,
  output logic                 rd_valid,
  output logic [add_width:0]   count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 mem_fault
);

  localparam logic [add_width:0] full_lvl =
    (add_width+1)'(depth);
  localparam logic [add_width:0] af_lvl =
    (add_width+1)'(depth - af_margin);

  logic [width-1:0]     mem [depth];
  logic [add_width-1:0] top_addr;
  logic [add_width-1:0] push_addr;
  logic [add_width-1:0] peek_addr;
  logic                 peek_ok;
  logic                 do_replace;
  logic                 do_push;

  // Flags and addresses decode straight from the count register.
  always_comb begin
    empty       = (count == '0);
    full        = (count == full_lvl);
    almost_full = (count >= af_lvl);
    top_addr    = add_width'(count - 1'b1);
    push_addr   = count[add_width-1:0];
    peek_addr   = top_addr - peek_off;
    peek_ok     = ({1'b0, peek_off} < count);
    do_replace  = push && pop && !empty;
    do_push     = push && !pop && !full;
  end

  // Array write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (rst && !clr) begin
      if (do_replace)
        mem[top_addr] <= wr;
      else if (do_push)
        mem[push_addr] <= wr;
    end
  end

  // Command sequencer: priority-ordered, one command per edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      rd        <= '0;
      rd_valid  <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      priority case (1'b1)
        clr: begin
          count     <= '0;
          mem_fault <= 1'b0;
        end
        push && pop: begin
          if (empty) begin
            mem_fault <= 1'b1;
          end else begin
            rd       <= mem[top_addr];
            rd_valid <= 1'b1;
          end
        end
        push: begin
          if (full)
            mem_fault <= 1'b1;
          else
            count <= count + 1'b1;
        end
        pop: begin
          if (empty) begin
            mem_fault <= 1'b1;
          end else begin
            rd       <= mem[top_addr];
            rd_valid <= 1'b1;
            count    <= count - 1'b1;
          end
        end
        peek: begin
          if (peek_ok) begin
            rd       <= mem[peek_addr];
            rd_valid <= 1'b1;
          end else begin
            mem_fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed vectors, read data checked by a
// scoreboard monitor, status checked after each command.
module tb_param_stack;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          push;
  logic          pop;
  logic          peek;
  logic [AW-1:0] peek_off;
  logic [W-1:0]  wr;
  logic [W-1:0]  rd;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          mem_fault;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [$];

  param_stack #(
    .width(W), .depth(D), .add_width(AW), .af_margin(1)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .push(push), .pop(pop), .peek(peek),
    .peek_off(peek_off), .wr(wr), .rd(rd),
    .rd_valid(rd_valid), .count(count),
    .empty(empty), .full(full),
    .almost_full(almost_full), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected none", rd);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rd !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", rd, e);
        end
      end
    end
  end

  task automatic idle();
    clr = 0; push = 0; pop = 0; peek = 0;
    peek_off = '0; wr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_push(input logic [W-1:0] d);
    push = 1; wr = d;
    step();
  endtask

  task automatic do_pop(input logic [W-1:0] e);
    exp_q.push_back(e);
    pop = 1;
    step();
  endtask

  task automatic do_peek(input logic [AW-1:0] o,
                         input logic [W-1:0] e,
                         input bit ok);
    if (ok) exp_q.push_back(e);
    peek = 1; peek_off = o;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_rd", rd, 0);
    check("rst_empty", empty, 1);
    check("rst_fault", mem_fault, 0);
    check("rst_valid", rd_valid, 0);
    rst = 1;

    do_push(16'h1111);
    do_push(16'h2222);
    check("af_at2", almost_full, 0);
    do_push(16'h3333);
    check("af_at3", almost_full, 1);
    check("full_at3", full, 0);
    do_push(16'h4444);
    check("count_full", count, 4);
    check("full", full, 1);
    check("af_at4", almost_full, 1);
    check("fault_clean", mem_fault, 0);

    do_push(16'h5555);
    check("ovf_fault", mem_fault, 1);
    check("ovf_count", count, 4);

    do_pop(16'h4444);
    do_pop(16'h3333);
    do_pop(16'h2222);
    do_pop(16'h1111);
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    pop = 1;
    step();
    check("unf_fault", mem_fault, 1);
    check("unf_rd", rd, 16'h1111);
    check("unf_valid", rd_valid, 0);

    clr = 1;
    step();
    check("clr_fault", mem_fault, 0);
    check("clr_count", count, 0);

    do_push(16'h000A);
    do_push(16'h000B);
    exp_q.push_back(16'h000B);
    push = 1; pop = 1; wr = 16'h000C;
    step();
    check("repl_count", count, 2);
    do_pop(16'h000C);
    check("repl_pop_count", count, 1);

    do_push(16'h000B);
    do_push(16'h000C);
    do_peek(2'd0, 16'h000C, 1);
    check("peek0_count", count, 3);
    do_peek(2'd2, 16'h000A, 1);
    check("peek2_count", count, 3);
    check("peek2_fault", mem_fault, 0);
    do_peek(2'd3, 16'h0000, 0);
    check("peek3_fault", mem_fault, 1);
    check("peek3_count", count, 3);
    check("peek3_rd", rd, 16'h000A);

    do_pop(16'h000C);
    check("pre_rst_count", count, 2);
    rst = 0; push = 1; wr = 16'h9999;
    step();
    check("mid_rst_count", count, 0);
    check("mid_rst_rd", rd, 0);
    check("mid_rst_fault", mem_fault, 0);
    rst = 1;
    do_push(16'h7777);
    check("post_rst_count", count, 1);
    do_pop(16'h7777);

    push = 1; pop = 1; wr = 16'h1234;
    step();
    check("repl_empty_fault", mem_fault, 1);
    check("repl_empty_count", count, 0);
    check("repl_empty_rd", rd, 16'h7777);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised hardware LIFO stack for the next-generation Neptune datapath. It replaces the fixed 256×16 stack with configurable width and depth. It adds occupancy reporting, full/empty/almost-full flags, a simultaneous push+pop (replace-top) operation, indexed peek below the top, synchronous clear, and a sticky fault flag. It sits between register file port I (write data) and the RF write-source mux (read data), and is driven by control-matrix push/pop/peek bits.

## Interface

Parameters:
- width, 16, data word width.
- depth, 256, number of entries; must be a power of two, ≥ 2.
- add_width, 8, log2(depth).
- af_margin, 4, almost_full asserts when count ≥ depth − af_margin; range 0 to depth−1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- clr  in  1  synchronous clear; empties the stack and clears mem_fault.
- push  in  1  push wr onto the stack.
- pop  in  1  remove the top entry and return it on rd.
- peek  in  1  read the entry at depth peek_off below the top without removing it; honoured only when push = pop = 0.
- peek_off  in  add_width  peek offset; 0 selects the top entry.
- wr  in  width  push data.
- rd  out  width  registered read data.
- rd_valid  out  1  one-cycle pulse: rd was updated by a successful pop or peek.
- count  out  add_width+1  current occupancy, 0 to depth.
- empty  out  1  count == 0.
- full  out  1  count == depth.
- almost_full  out  1  count ≥ depth − af_margin.
- mem_fault  out  1  sticky error flag.

## Operation

- Storage: depth × width array. Stack pointer sp = count; the top entry is mem[sp−1]. Array contents are not reset.
- Commands are evaluated each clock edge in priority order:
  1. rst = 0: count ← 0, rd ← 0, rd_valid ← 0, mem_fault ← 0.
  2. clr = 1: count ← 0, mem_fault ← 0, rd_valid ← 0. rd holds. push, pop and peek are ignored that cycle.
  3. push & pop, not empty: replace top. rd ← mem[sp−1] (old top), mem[sp−1] ← wr, count unchanged, rd_valid ← 1. Valid when full.
  4. push & pop, empty: mem_fault ← 1. No write, rd holds, rd_valid ← 0.
  5. push only: if not full, mem[sp] ← wr and count ← count+1. If full, mem_fault ← 1 and nothing else changes.
  6. pop only: if not empty, rd ← mem[sp−1], count ← count−1, rd_valid ← 1. If empty, mem_fault ← 1, rd holds, rd_valid ← 0.
  7. peek only: if peek_off < count, rd ← mem[sp−1−peek_off] and rd_valid ← 1. Otherwise mem_fault ← 1 and rd holds.
  8. No command: rd holds, rd_valid ← 0.
- A peek that coincides with push or pop is ignored silently; no fault is raised.
- mem_fault is sticky. Only rst = 0 or clr = 1 clears it. Operations continue normally while it is set.
- Flags are combinational decodes of the count register, so they are glitch-free at the register boundary.
- Pointer arithmetic is done at add_width+1 bits. Address wrap-around never occurs because overflow and underflow are blocked.

## Timing

- Read latency is 1 cycle: rd and rd_valid are valid in the cycle after pop or peek is sampled.
- A pushed word is visible to a pop or peek issued in the very next cycle (write-then-read, no bubble).
- count, empty, full and almost_full reflect an operation in the cycle after it is sampled.
- Back-to-back push or pop is supported every cycle. Throughput is 1 operation per clock.
- Reset takes effect on the edge where rst is sampled low, including mid-sequence. The outputs listed under Operation step 1 are at their reset values in the following cycle. The cycle after rst returns high accepts commands.
- mem_fault rises in the cycle after the offending command and stays high.

## Test plan

All scenarios use width = 16, depth = 4, af_margin = 1.

- Reset, then push 0x1111, 0x2222, 0x3333, 0x4444 → count = 4, full = 1, almost_full asserts from count = 3, mem_fault = 0.
- Push 0x5555 while full → mem_fault = 1, count stays 4. Then 4 pops → rd sequence 0x4444, 0x3333, 0x2222, 0x1111 with rd_valid each cycle, empty = 1.
- Pop when empty → mem_fault = 1, rd holds 0x1111, rd_valid = 0. Then clr → mem_fault = 0, count = 0.
- Push 0xA, 0xB, then push+pop with wr = 0xC → rd = 0xB, count = 2. Then pop → rd = 0xC.
- With 0xA, 0xB, 0xC stacked: peek_off 0 → rd = 0xC; peek_off 2 → rd = 0xA; peek_off 3 → mem_fault = 1. count stays 3 throughout.
- Assert rst = 0 during a run of pushes at count = 2 → next cycle count = 0, rd = 0, mem_fault = 0. A push after release gives count = 1.
